// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: 16 lines of 4 words, refilled one word at a
// time from a shared main memory that can give priority to the data side.
module instruction_cache #(
    parameter int ADDR_WIDTH       = 17,
    parameter int DATA_LEN         = 32,
    parameter int BYTE_SIZE        = 8,
    parameter int INDEX_SIZE       = 4,
    parameter int WORD_OFFSET_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  flush,
    output logic                  inst_valid,
    output logic [DATA_LEN-1:0]   inst,
    output logic [1:0]            mem_vis_signal,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    input  logic [DATA_LEN-1:0]   mem_data,
    input  logic [1:0]            mem_status
);

    localparam int unsigned BYTES = DATA_LEN / BYTE_SIZE;
    localparam int unsigned BOFF  = $clog2(BYTES);
    localparam int unsigned TAG_W = ADDR_WIDTH - INDEX_SIZE - WORD_OFFSET_SIZE - BOFF;
    localparam int unsigned LINES = 1 << INDEX_SIZE;
    localparam int unsigned WORDS = 1 << WORD_OFFSET_SIZE;

    // Memory request and status encodings shared with main memory
    localparam logic [1:0] MEM_NOP           = 2'b00;
    localparam logic [1:0] MEM_READ          = 2'b01;
    localparam logic [1:0] MEM_INST_FINISHED = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND
    } state_t;

    state_t state;

    logic [TAG_W-1:0]    tags  [LINES];
    logic [DATA_LEN-1:0] lines [LINES][WORDS];
    logic [LINES-1:0]    valid;

    logic [TAG_W-1:0]            req_tag;
    logic [INDEX_SIZE-1:0]       req_index;
    logic [WORD_OFFSET_SIZE-1:0] req_word;
    logic [WORD_OFFSET_SIZE-1:0] counter;
    logic                        issued;

    logic [TAG_W-1:0]            f_tag;
    logic [INDEX_SIZE-1:0]       f_index;
    logic [WORD_OFFSET_SIZE-1:0] f_word;
    logic                        hit;
    logic                        capture;
    logic                        unused_byte_bits;

    assign f_tag            = fetch_addr[ADDR_WIDTH-1 -: TAG_W];
    assign f_index          = fetch_addr[BOFF+WORD_OFFSET_SIZE +: INDEX_SIZE];
    assign f_word           = fetch_addr[BOFF +: WORD_OFFSET_SIZE];
    assign unused_byte_bits = ^fetch_addr[BOFF-1:0];
    assign hit              = valid[f_index] && (tags[f_index] == f_tag);

    // A word is accepted only on the cycle after its read, when memory reports the instruction side finished
    assign capture = (state == REFILL) && issued && !flush && (mem_status == MEM_INST_FINISHED);

    // Memory memory is stored in memory order; the core expects little-endian instructions
    function automatic logic [DATA_LEN-1:0] swap_bytes(input logic [DATA_LEN-1:0] w);
        logic [DATA_LEN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            r[i*BYTE_SIZE +: BYTE_SIZE] = w[(BYTES-1-i)*BYTE_SIZE +: BYTE_SIZE];
        end
        return r;
    endfunction

    // Read request is decoded from registered state so flush can drop it in the same cycle
    assign mem_vis_signal = ((state == REFILL) && !issued && !flush) ? MEM_READ : MEM_NOP;
    assign mem_vis_addr   = {req_tag, req_index, counter, {BOFF{1'b0}}};

    // Line storage: data words land as they arrive, the tag with the final word
    always_ff @(posedge clk) begin
        if (capture) begin
            lines[req_index][counter] <= mem_data;
            if (counter == '1) begin
                tags[req_index] <= req_tag;
            end
        end
    end

    // Control FSM: hit response, word-by-word refill, and the post-refill response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            req_tag    <= '0;
            req_index  <= '0;
            req_word   <= '0;
            counter    <= '0;
            issued     <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (flush) begin
                valid  <= '0;
                issued <= 1'b0;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fetch_req) begin
                            if (hit) begin
                                inst_valid <= 1'b1;
                                inst       <= swap_bytes(lines[f_index][f_word]);
                            end else begin
                                req_tag        <= f_tag;
                                req_index      <= f_index;
                                req_word       <= f_word;
                                counter        <= '0;
                                issued         <= 1'b0;
                                // The line is overwritten word by word, so it must not hit on its old tag
                                valid[f_index] <= 1'b0;
                                state          <= REFILL;
                            end
                        end
                    end
                    REFILL: begin
                        if (!issued) begin
                            issued <= 1'b1;
                        end else begin
                            // Any status other than ours means the data side won; the same word is reissued
                            issued <= 1'b0;
                            if (mem_status == MEM_INST_FINISHED) begin
                                counter <= counter + 1'b1;
                                if (counter == '1) begin
                                    valid[req_index] <= 1'b1;
                                    state            <= RESPOND;
                                end
                            end
                        end
                    end
                    RESPOND: begin
                        inst_valid <= 1'b1;
                        inst       <= swap_bytes(lines[req_index][req_word]);
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus random
// fetches, checked against a tag/valid cache model and a byte-array memory.
module tb_instruction_cache;

    localparam logic [1:0] MEM_NOP           = 2'b00;
    localparam logic [1:0] MEM_READ          = 2'b01;
    localparam logic [1:0] MEM_RESTING       = 2'b00;
    localparam logic [1:0] MEM_INST_FINISHED = 2'b01;
    localparam logic [1:0] MEM_DATA_FINISHED = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [16:0] fetch_addr;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic [1:0]  mem_vis_signal;
    logic [16:0] mem_vis_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_status;

    int compared;
    int mismatched;

    logic [7:0]  mem [0:(1<<17)-1];
    logic [16:0] reads[$];
    logic [16:0] deny_addr;
    int          deny_token;
    int          deny_done;
    logic        prev_read;

    bit [15:0]   model_valid;
    logic [8:0]  model_tag [16];

    instruction_cache #(
        .ADDR_WIDTH(17),
        .DATA_LEN(32),
        .BYTE_SIZE(8),
        .INDEX_SIZE(4),
        .WORD_OFFSET_SIZE(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .flush(flush),
        .inst_valid(inst_valid),
        .inst(inst),
        .mem_vis_signal(mem_vis_signal),
        .mem_vis_addr(mem_vis_addr),
        .mem_data(mem_data),
        .mem_status(mem_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: one-cycle read response; a planted denial answers with the data-side status and junk
    always @(posedge clk) begin
        mem_status <= MEM_RESTING;
        mem_data   <= $urandom;
        if (rst_n && mem_vis_signal == MEM_READ) begin
            reads.push_back(mem_vis_addr);
            if (deny_done != deny_token && mem_vis_addr == deny_addr) begin
                deny_done  = deny_token;
                mem_status <= MEM_DATA_FINISHED;
            end else begin
                mem_status <= MEM_INST_FINISHED;
                mem_data   <= {mem[mem_vis_addr], mem[mem_vis_addr+17'd1],
                               mem[mem_vis_addr+17'd2], mem[mem_vis_addr+17'd3]};
            end
        end
    end

    // Read requests must never be back to back
    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_vis_signal == MEM_READ) begin
                compared++;
                assert (prev_read === 1'b0) else begin
                    mismatched++;
                    $error("FAIL read_b2b: observed %0b expected 0", prev_read);
                end
            end
            prev_read = (mem_vis_signal == MEM_READ);
        end else begin
            prev_read = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] le_word(input logic [16:0] a);
        logic [16:0] w;
        w = a & ~17'd3;
        return {mem[w+17'd3], mem[w+17'd2], mem[w+17'd1], mem[w]};
    endfunction

    task automatic do_fetch(input logic [16:0] addr, input logic with_flush,
                            input logic deny, input logic [1:0] deny_word);
        logic [16:0] base;
        logic [3:0]  idx;
        logic [8:0]  tg;
        logic        exp_hit;
        int          exp_lat;
        int          lat;
        logic        got;
        logic [31:0] exp_inst;
        logic [16:0] exp_reads[$];
        base = addr & ~17'd15;
        idx  = addr[7:4];
        tg   = addr[16:8];
        if (with_flush) model_valid = '0;
        exp_hit  = model_valid[idx] && model_tag[idx] == tg;
        exp_inst = le_word(addr);
        exp_lat  = exp_hit ? 1 : 10 + (with_flush ? 1 : 0) + ((deny && !exp_hit) ? 2 : 0);
        if (!exp_hit) begin
            for (int w = 0; w < 4; w++) begin
                exp_reads.push_back(base + 17'(4 * w));
                if (deny && w == int'(deny_word)) exp_reads.push_back(base + 17'(4 * w));
            end
            if (deny) begin
                deny_addr = base + 17'(4 * int'(deny_word));
                deny_token++;
            end
        end
        reads.delete();
        fetch_req  = 1'b1;
        fetch_addr = addr;
        flush      = with_flush;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            flush = 1'b0;
            lat++;
            got = inst_valid;
            if (!got && lat >= 2) fetch_addr = 17'($urandom);
        end
        fetch_req = 1'b0;
        check("inst_valid_seen", {31'd0, got}, 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("inst", inst, exp_inst);
        check("read_count", 32'(reads.size()), 32'(exp_reads.size()));
        for (int i = 0; i < exp_reads.size() && i < reads.size(); i++)
            check("read_addr", {15'd0, reads[i]}, {15'd0, exp_reads[i]});
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tg;
        @(posedge clk);
        #1;
        check("pulse_len", {31'd0, inst_valid}, 32'd0);
        check("inst_hold", inst, exp_inst);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] a;
        logic        seen;
        compared    = 0;
        mismatched  = 0;
        deny_token  = 0;
        deny_done   = 0;
        deny_addr   = '0;
        prev_read   = 1'b0;
        model_valid = '0;
        for (int i = 0; i < 16; i++) model_tag[i] = '0;
        for (int i = 0; i < (1 << 17); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
        #1;
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_mem_sig", {30'd0, mem_vis_signal}, {30'd0, MEM_NOP});
        check("rst_mem_addr", {15'd0, mem_vis_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, then a hit in the same line
        do_fetch(17'h0000, 1'b0, 1'b0, 2'd0);
        check("cold_inst_13", inst, 32'h0000_0013);
        do_fetch(17'h0008, 1'b0, 1'b0, 2'd0);
        // Data-side priority on word 1
        do_fetch(17'h0046, 1'b0, 1'b1, 2'd1);
        // Conflict on index 0
        do_fetch(17'h0100, 1'b0, 1'b0, 2'd0);
        do_fetch(17'h0000, 1'b0, 1'b0, 2'd0);

        // Flush while word 2 of a refill is outstanding
        reads.delete();
        fetch_req  = 1'b1;
        fetch_addr = 17'h0080;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = (mem_vis_signal == MEM_READ && mem_vis_addr == 17'h0088);
        end
        check("flush_word2_reached", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        fetch_req = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_mem_nop", {30'd0, mem_vis_signal}, {30'd0, MEM_NOP});
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (inst_valid || mem_vis_signal != MEM_NOP) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush_quiet", {31'd0, seen}, 32'd0);
        model_valid = '0;
        do_fetch(17'h0080, 1'b0, 1'b0, 2'd0);
        do_fetch(17'h0000, 1'b0, 1'b0, 2'd0);
        // Flush arriving with a request that would have hit
        do_fetch(17'h0084, 1'b1, 1'b0, 2'd0);

        // Reset in the middle of a refill
        fetch_req  = 1'b1;
        fetch_addr = 17'h00C0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("midrst_inst", inst, 32'd0);
        check("midrst_mem_sig", {30'd0, mem_vis_signal}, {30'd0, MEM_NOP});
        check("midrst_mem_addr", {15'd0, mem_vis_addr}, 32'd0);
        fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_valid = '0;
        @(posedge clk);
        #1;
        do_fetch(17'h00C0, 1'b0, 1'b0, 2'd0);

        // Random fetches over a few tags to mix hits, conflicts, flushes and denials
        for (int n = 0; n < 60; n++) begin
            a = {9'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom)};
            do_fetch(a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                     2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, byte-address width; SHALL match main memory.
REQ-002 Parameter DATA_LEN, default 32, word and instruction width.
REQ-003 Parameter BYTE_SIZE, default 8, bits per byte.
REQ-004 Parameter INDEX_SIZE, default 4, giving 16 direct-mapped lines.
REQ-005 Parameter WORD_OFFSET_SIZE, default 2, giving 4 words (16 bytes) per line.
REQ-006 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1, reset; SHALL be asynchronous and active-low.
REQ-008 Port fetch_req, input, 1, core fetch request; held high with a stable address until inst_valid.
REQ-009 Port fetch_addr, input, ADDR_WIDTH, fetch byte address; bits [1:0] are ignored.
REQ-010 Port flush, input, 1, fence.i; invalidates all lines.
REQ-011 Port inst_valid, output, 1, one-cycle pulse marking inst valid.
REQ-012 Port inst, output, DATA_LEN, fetched instruction in RISC-V little-endian order.
REQ-013 Port mem_vis_signal, output, 2, drives the main memory instruction-side request with `MEM_NOP or `MEM_READ only.
REQ-014 Port mem_vis_addr, output, ADDR_WIDTH, word-aligned refill address to main memory.
REQ-015 Port mem_data, input, DATA_LEN, main memory read data; the byte at the lowest address is in [31:24].
REQ-016 Port mem_status, input, 2, main memory status (`MEM_RESTING, `MEM_INST_FINISHED or `MEM_DATA_FINISHED).

Function
REQ-017 Address split SHALL be: [1:0] byte, [3:2] word, [7:4] index, [ADDR_WIDTH-1:8] tag (9 bits at default).
REQ-018 Storage per line SHALL be: 1 valid bit, tag, and 4 x DATA_LEN data words.
REQ-019 FSM states SHALL be IDLE, REFILL and RESPOND.
REQ-020 IDLE, fetch_req high with valid line and tag match (hit): inst_valid SHALL pulse on the next cycle with the word; state stays IDLE; total latency 1 cycle.
REQ-021 IDLE, fetch_req high and no hit (miss): SHALL latch fetch_addr, clear word counter and issued flag, and go to REFILL.
REQ-022 REFILL with issued=0: SHALL drive `MEM_READ and mem_vis_addr = {latched tag, index, counter, 2'b00}, then set issued=1.
REQ-023 REFILL with issued=1: SHALL drive `MEM_NOP and sample mem_status on that cycle.
REQ-024 In REFILL with issued=1, status `MEM_INST_FINISHED: SHALL store mem_data into word[counter], increment counter, and clear issued.
REQ-025 In REFILL with issued=1, any other status (the data cache took priority): SHALL discard mem_data, clear issued, and reissue the same word.
REQ-026 After word 3 is captured, SHALL write the tag, set valid, and go to RESPOND; minimum refill time is 8 cycles.
REQ-027 RESPOND: SHALL pulse inst_valid with the requested word and return to IDLE; a miss costs at least 10 cycles from request to inst_valid.
REQ-028 inst SHALL equal {mem byte+3, byte+2, byte+1, byte+0}, i.e. the stored memory word byte-reversed; the byte swap is applied on output.
REQ-029 fetch_req low in IDLE: inst_valid SHALL stay 0; fetch_addr changes while busy SHALL be ignored.
REQ-030 inst SHALL hold its last value when inst_valid is 0.
REQ-031 flush in any state: SHALL clear all valid bits in that cycle, drop mem_vis_signal to `MEM_NOP, abort any refill without setting valid, suppress inst_valid, and go to IDLE.
REQ-032 flush together with fetch_req in IDLE: the request SHALL be treated as a miss on the next cycle, not a hit.
REQ-033 mem_vis_signal SHALL never hold `MEM_READ for two consecutive cycles.

Reset
REQ-034 While rst_n is low: state = IDLE, all valid bits = 0, inst_valid = 0, inst = 0, mem_vis_signal = `MEM_NOP, mem_vis_addr = 0, counter = 0, issued = 0.
REQ-035 rst_n asserted mid-refill SHALL abort immediately; the partial line SHALL NOT become valid.

Verification
REQ-036 Cold miss: memory 0x0000..0x000F = 13 00 00 00 ... ; fetch 0x0000 -> READs 0x0,0x4,0x8,0xC on alternating cycles; inst_valid at cycle 10; inst = 0x00000013.
REQ-037 Hit: after REQ-036, fetch 0x0008 -> inst_valid next cycle with swapped word 2; mem_vis_signal stays `MEM_NOP.
REQ-038 Data priority: force mem_status = `MEM_DATA_FINISHED on the first sample of word 1 -> 0x0004 reissued; line still correct; inst_valid at cycle 12.
REQ-039 Conflict: fetch 0x0000 then 0x0100 (same index, different tag) -> second is a miss and refills; fetch 0x0000 again -> miss.
REQ-040 Flush: flush during word 2 of a refill -> no inst_valid, `MEM_NOP next cycle; refetch of the same address -> full miss.
REQ-041 Reset: drop rst_n mid-refill -> all outputs at reset values asynchronously; after release, fetch of the same address -> miss.
